// File: rtl/data_cache_assoc.sv
// N-way set-associative write-back/write-allocate data cache with true-LRU replacement,
// dirty-victim writeback, sign/zero-extending loads and byte-lane stores.
module data_cache_assoc #(
    parameter int WAYS       = 2,
    parameter int SETS       = 8,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [3:0]                            read,
    input  logic [2:0]                            write,
    input  logic [ADDR_W-1:0]                     address,
    input  logic [31:0]                           writedata,
    output logic [31:0]                           readdata,
    output logic                                  busywait,
    output logic                                  MAIN_MEM_READ,
    output logic                                  MAIN_MEM_WRITE,
    output logic [ADDR_W-$clog2(4*LINE_WORDS)-1:0] MAIN_MEM_ADDRESS,
    output logic [32*LINE_WORDS-1:0]              MAIN_MEM_WRITE_DATA,
    input  logic [32*LINE_WORDS-1:0]              MAIN_MEM_READ_DATA,
    input  logic                                  MAIN_MEM_BUSY_WAIT
);

    localparam int OFF    = $clog2(4*LINE_WORDS);
    localparam int IDX    = $clog2(SETS);
    localparam int TAG    = ADDR_W - IDX - OFF;
    localparam int LINE_W = 32*LINE_WORDS;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [WAY_W-1:0] OLDEST = WAY_W'(WAYS-1);

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;

    state_t state;

    logic [LINE_W-1:0] data_mem   [WAYS][SETS];
    logic [TAG-1:0]    tag_mem    [WAYS][SETS];
    logic              valid_bits [WAYS][SETS];
    logic              dirty_bits [WAYS][SETS];
    logic [WAY_W-1:0]  age        [WAYS][SETS];

    logic [TAG-1:0]    req_tag;
    logic [IDX-1:0]    req_idx;
    logic [OFF-1:0]    word_sel;
    logic              access;
    logic              store_req;

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim;
    logic              found_invalid;
    logic [LINE_W-1:0] hit_line;
    logic [31:0]       hit_word;
    logic [31:0]       load_word;
    logic [31:0]       byte_shift;
    logic [31:0]       half_shift;
    logic [3:0]        byte_en;
    logic [31:0]       store_word;
    logic [LINE_W-1:0] merged_line;
    logic              store_hit;

    logic [TAG-1:0]    tag_q;
    logic [IDX-1:0]    idx_q;
    logic [WAY_W-1:0]  victim_q;
    logic [LINE_W-1:0] fill_line;

    logic [WAY_W-1:0]  lru_way;
    logic [IDX-1:0]    lru_set;
    logic [WAY_W-1:0]  lru_old;
    logic [WAY_W-1:0]  new_age [WAYS];

    assign req_tag   = address[ADDR_W-1 -: TAG];
    assign req_idx   = address[OFF +: IDX];
    assign word_sel  = address[OFF-1:0] >> 2;
    assign store_req = write[2];
    assign access    = read[3] | write[2];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit && valid_bits[w][req_idx] && (tag_mem[w][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Invalid ways are filled lowest-first; only a full set falls back to the oldest age.
    always_comb begin
        victim        = '0;
        found_invalid = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!found_invalid && !valid_bits[w][req_idx]) begin
                victim        = WAY_W'(w);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age[w][req_idx] == OLDEST) victim = WAY_W'(w);
            end
        end
    end

    assign hit_line = data_mem[hit_way][req_idx];

    always_comb begin
        hit_word = '0;
        for (int unsigned w = 0; w < LINE_WORDS; w++) begin
            if (w == 32'(word_sel)) hit_word = hit_line[w*32 +: 32];
        end
    end

    assign byte_shift = hit_word >> {address[1:0], 3'b000};
    assign half_shift = hit_word >> {address[1], 4'b0000};

    always_comb begin
        case (read[2:0])
            3'b000:  load_word = {{24{byte_shift[7]}}, byte_shift[7:0]};
            3'b001:  load_word = {{16{half_shift[15]}}, half_shift[15:0]};
            3'b010:  load_word = hit_word;
            3'b100:  load_word = {24'b0, byte_shift[7:0]};
            3'b101:  load_word = {16'b0, half_shift[15:0]};
            default: load_word = '0;
        endcase
    end

    assign readdata = (state == IDLE && hit && read[3] && !store_req) ? load_word : '0;
    assign busywait = reset && ((state != IDLE) || (access && !hit));

    always_comb begin
        case (write[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << address[1:0];
                store_word = {4{writedata[7:0]}};
            end
            2'b01: begin
                byte_en    = address[1] ? 4'b1100 : 4'b0011;
                store_word = {2{writedata[15:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                store_word = writedata;
            end
        endcase
    end

    always_comb begin
        merged_line = hit_line;
        for (int unsigned w = 0; w < LINE_WORDS; w++) begin
            if (w == 32'(word_sel)) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (byte_en[b]) merged_line[w*32 + b*8 +: 8] = store_word[b*8 +: 8];
                end
            end
        end
    end

    assign store_hit = (state == IDLE) && store_req && hit;

    // The same age update serves both a hit in IDLE and the fill in UPDATE.
    always_comb begin
        lru_way = (state == UPDATE) ? victim_q : hit_way;
        lru_set = (state == UPDATE) ? idx_q : req_idx;
        lru_old = age[lru_way][lru_set];
        for (int unsigned w = 0; w < WAYS; w++) begin
            new_age[w] = age[w][lru_set];
            if (WAY_W'(w) == lru_way)
                new_age[w] = '0;
            else if (age[w][lru_set] < lru_old)
                new_age[w] = age[w][lru_set] + WAY_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (store_hit)
            data_mem[hit_way][req_idx] <= merged_line;
        if (state == ALLOCATE && !MAIN_MEM_BUSY_WAIT)
            fill_line <= MAIN_MEM_READ_DATA;
        if (state == UPDATE) begin
            data_mem[victim_q][idx_q] <= fill_line;
            tag_mem[victim_q][idx_q]  <= tag_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            MAIN_MEM_READ       <= 1'b0;
            MAIN_MEM_WRITE      <= 1'b0;
            MAIN_MEM_ADDRESS    <= '0;
            MAIN_MEM_WRITE_DATA <= '0;
            tag_q               <= '0;
            idx_q               <= '0;
            victim_q            <= '0;
            for (int unsigned w = 0; w < WAYS; w++) begin
                for (int unsigned s = 0; s < SETS; s++) begin
                    valid_bits[w][s] <= 1'b0;
                    dirty_bits[w][s] <= 1'b0;
                    age[w][s]        <= WAY_W'(w);
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (hit) begin
                            for (int unsigned w = 0; w < WAYS; w++)
                                age[w][lru_set] <= new_age[w];
                            if (store_req)
                                dirty_bits[hit_way][req_idx] <= 1'b1;
                        end else begin
                            tag_q    <= req_tag;
                            idx_q    <= req_idx;
                            victim_q <= victim;
                            if (valid_bits[victim][req_idx] && dirty_bits[victim][req_idx]) begin
                                state               <= WRITEBACK;
                                MAIN_MEM_WRITE      <= 1'b1;
                                MAIN_MEM_ADDRESS    <= {tag_mem[victim][req_idx], req_idx};
                                MAIN_MEM_WRITE_DATA <= data_mem[victim][req_idx];
                            end else begin
                                state            <= ALLOCATE;
                                MAIN_MEM_READ    <= 1'b1;
                                MAIN_MEM_ADDRESS <= {req_tag, req_idx};
                            end
                        end
                    end
                end
                WRITEBACK: begin
                    if (!MAIN_MEM_BUSY_WAIT) begin
                        state            <= ALLOCATE;
                        MAIN_MEM_WRITE   <= 1'b0;
                        MAIN_MEM_READ    <= 1'b1;
                        MAIN_MEM_ADDRESS <= {tag_q, idx_q};
                    end
                end
                ALLOCATE: begin
                    if (!MAIN_MEM_BUSY_WAIT) begin
                        state         <= UPDATE;
                        MAIN_MEM_READ <= 1'b0;
                    end
                end
                UPDATE: begin
                    state                      <= IDLE;
                    valid_bits[victim_q][idx_q] <= 1'b1;
                    dirty_bits[victim_q][idx_q] <= 1'b0;
                    for (int unsigned w = 0; w < WAYS; w++)
                        age[w][lru_set] <= new_age[w];
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache_assoc.sv
// Directed bench for data_cache_assoc (2 ways, 8 sets, 4-word lines) against a
// latency-programmable main memory whose line L holds words 0xA0000000 ^ (L<<8) ^ k.
module tb_data_cache_assoc;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   read;
    logic [2:0]   write;
    logic [31:0]  address;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic         busywait;
    logic         mm_read;
    logic         mm_write;
    logic [27:0]  mm_addr;
    logic [127:0] mm_wdata;
    logic [127:0] mm_rdata;
    logic         mm_busy;

    int lat = 2;
    int cnt = 0;
    int total = 0;
    int bad = 0;
    int wb_n = 0;
    int fill_n = 0;
    int ev_seq = 0;
    int wb_seq = 0;
    int fill_seq = 0;
    logic [27:0]  wb_addr = '0;
    logic [27:0]  fill_addr = '0;
    logic [127:0] wb_data = '0;

    data_cache_assoc #(.WAYS(2), .SETS(8), .LINE_WORDS(4), .ADDR_W(32)) dut (
        .clock               (clock),
        .reset               (reset),
        .read                (read),
        .write               (write),
        .address             (address),
        .writedata           (writedata),
        .readdata            (readdata),
        .busywait            (busywait),
        .MAIN_MEM_READ       (mm_read),
        .MAIN_MEM_WRITE      (mm_write),
        .MAIN_MEM_ADDRESS    (mm_addr),
        .MAIN_MEM_WRITE_DATA (mm_wdata),
        .MAIN_MEM_READ_DATA  (mm_rdata),
        .MAIN_MEM_BUSY_WAIT  (mm_busy)
    );

    always #5 clock = ~clock;

    always_comb begin
        for (int k = 0; k < 4; k++)
            mm_rdata[k*32 +: 32] = 32'hA000_0000 ^ ({4'h0, mm_addr} << 8) ^ 32'(k);
    end

    assign mm_busy = (mm_read || mm_write) && (cnt != lat);

    always @(posedge clock) begin
        if ((mm_read || mm_write) && cnt != lat) cnt <= cnt + 1;
        else cnt <= 0;
    end

    // Completed memory transactions, logged one half-cycle before the accepting edge.
    always @(negedge clock) begin
        if (mm_write && !mm_busy) begin
            wb_n++;
            wb_addr = mm_addr;
            wb_data = mm_wdata;
            wb_seq  = ev_seq;
            ev_seq++;
        end
        if (mm_read && !mm_busy) begin
            fill_n++;
            fill_addr = mm_addr;
            fill_seq  = ev_seq;
            ev_seq++;
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_access(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                             input logic [31:0] wd, output logic [31:0] data,
                             output int cycles, output logic first_busy);
        @(negedge clock);
        read = rd; write = wr; address = addr; writedata = wd;
        #1;
        first_busy = busywait;
        cycles = 0;
        while (busywait && cycles < 100) begin
            @(negedge clock);
            #1;
            cycles++;
        end
        if (busywait) check_eq("stall_timeout", busywait, 1'b0);
        data = readdata;
        @(posedge clock);
        #1;
        read = '0; write = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int          cyc;
        logic        fb;
        int          wb0;

        reset = 1'b0; read = '0; write = '0; address = '0; writedata = '0;
        repeat (2) @(negedge clock);
        read = 4'b1010; address = 32'h40;
        #1;
        check_eq("rst_busywait", busywait, 1'b0);
        check_eq("rst_readdata", readdata, 32'h0);
        check_eq("rst_mm_read",  mm_read,  1'b0);
        check_eq("rst_mm_write", mm_write, 1'b0);
        check_eq("rst_mm_addr",  mm_addr,  28'h0);
        check_eq("rst_mm_wdata", mm_wdata, 128'h0);
        read = '0;
        @(negedge clock);
        reset = 1'b1;

        // Cold miss then hit
        lat = 2;
        do_access(4'b1010, 3'b000, 32'h40, 32'h0, d, cyc, fb);
        check_eq("miss_first_busy", fb, 1'b1);
        check_eq("miss_cycles", cyc, 5);
        check_eq("miss_fill_n", fill_n, 1);
        check_eq("miss_fill_addr", fill_addr, 28'h4);
        check_eq("miss_data", d, 32'hA000_0400);
        do_access(4'b1010, 3'b000, 32'h44, 32'h0, d, cyc, fb);
        check_eq("hit_first_busy", fb, 1'b0);
        check_eq("hit_cycles", cyc, 0);
        check_eq("hit_data", d, 32'hA000_0401);
        check_eq("hit_no_fill", fill_n, 1);

        // Byte/half stores and sign/zero-extended loads
        do_access(4'b1010, 3'b000, 32'h80, 32'h0, d, cyc, fb);
        check_eq("line8_data", d, 32'hA000_0800);
        do_access(4'b0000, 3'b100, 32'h80, 32'h0000_00A5, d, cyc, fb);
        check_eq("sb_hit_cycles", cyc, 0);
        do_access(4'b1000, 3'b000, 32'h80, 32'h0, d, cyc, fb);
        check_eq("lb", d, 32'hFFFF_FFA5);
        do_access(4'b1100, 3'b000, 32'h80, 32'h0, d, cyc, fb);
        check_eq("lbu", d, 32'h0000_00A5);
        do_access(4'b1001, 3'b000, 32'h80, 32'h0, d, cyc, fb);
        check_eq("lh", d, 32'h0000_08A5);
        do_access(4'b0000, 3'b101, 32'h86, 32'h1234_BEEF, d, cyc, fb);
        do_access(4'b1101, 3'b000, 32'h86, 32'h0, d, cyc, fb);
        check_eq("lhu_hi", d, 32'h0000_BEEF);
        do_access(4'b1001, 3'b000, 32'h86, 32'h0, d, cyc, fb);
        check_eq("lh_hi", d, 32'hFFFF_BEEF);
        do_access(4'b1010, 3'b000, 32'h84, 32'h0, d, cyc, fb);
        check_eq("lw_after_sh", d, 32'hBEEF_0801);

        // LRU in set 4: A=line 4, B=line 12, C=line 20
        do_access(4'b1010, 3'b000, 32'hC0, 32'h0, d, cyc, fb);
        check_eq("lru_b_fill", cyc, 5);
        do_access(4'b1010, 3'b000, 32'h40, 32'h0, d, cyc, fb);
        check_eq("lru_touch_a", cyc, 0);
        do_access(4'b1010, 3'b000, 32'h140, 32'h0, d, cyc, fb);
        check_eq("lru_c_fill_addr", fill_addr, 28'h14);
        check_eq("lru_c_data", d, 32'hA000_1400);
        do_access(4'b1010, 3'b000, 32'h40, 32'h0, d, cyc, fb);
        check_eq("lru_a_still_hits", cyc, 0);
        check_eq("lru_a_data", d, 32'hA000_0400);
        do_access(4'b1010, 3'b000, 32'hC0, 32'h0, d, cyc, fb);
        check_eq("lru_b_evicted", cyc, 5);
        check_eq("clean_no_wb", wb_n, 0);

        // Dirty eviction in set 0 with a 5-cycle memory
        lat = 5;
        do_access(4'b1010, 3'b000, 32'h100, 32'h0, d, cyc, fb);
        check_eq("set0_second_fill", cyc, 8);
        wb0 = wb_n;
        do_access(4'b1010, 3'b000, 32'h180, 32'h0, d, cyc, fb);
        check_eq("dirty_cycles", cyc, 14);
        check_eq("dirty_wb_n", wb_n, wb0 + 1);
        check_eq("dirty_wb_addr", wb_addr, 28'h8);
        check_eq("dirty_wb_data", wb_data,
                 {32'hA000_0803, 32'hA000_0802, 32'hBEEF_0801, 32'hA000_08A5});
        check_eq("wb_before_fill", 32'(wb_seq < fill_seq), 32'd1);
        check_eq("dirty_fill_addr", fill_addr, 28'h18);
        check_eq("dirty_data", d, 32'hA000_1800);

        // Reset during ALLOCATE
        @(negedge clock);
        read = 4'b1010; address = 32'h1C0;
        #1;
        check_eq("abort_busy", busywait, 1'b1);
        repeat (2) @(negedge clock);
        #1;
        check_eq("abort_alloc_strobe", mm_read, 1'b1);
        reset = 1'b0;
        #1;
        check_eq("abort_read_drop", mm_read, 1'b0);
        check_eq("abort_busy_drop", busywait, 1'b0);
        check_eq("abort_addr_clear", mm_addr, 28'h0);
        @(negedge clock);
        read = '0;
        reset = 1'b1;
        do_access(4'b1010, 3'b000, 32'h100, 32'h0, d, cyc, fb);
        check_eq("post_reset_miss", cyc, 8);
        check_eq("post_reset_fill", fill_addr, 28'h10);
        check_eq("post_reset_data", d, 32'hA000_1000);

        // Load and store together: store wins, no read data
        do_access(4'b1010, 3'b110, 32'h100, 32'h1234_5678, d, cyc, fb);
        check_eq("both_readdata", d, 32'h0);
        check_eq("both_hit", cyc, 0);
        do_access(4'b1010, 3'b000, 32'h100, 32'h0, d, cyc, fb);
        check_eq("both_stored", d, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
